vga_scanout: RTL and testbench

//  Framebuffer read side of the VGA path. Runs 640x480@60 timing on the pixel clock and reads

---
 rtl/vga_pkg.sv | 44 ++++
 rtl/vga_palette.sv | 29 ++
 rtl/vga_scanout.sv | 106 ++++++++++
 tb/tb_vga_scanout.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants, pipeline tag type and RGB332 palette seed.
package vga_pkg;
    localparam int H_VISIBLE      = 640;
    localparam int H_FRONT        = 16;
    localparam int H_SYNC         = 96;
    localparam int H_BACK         = 48;
    localparam int V_VISIBLE      = 480;
    localparam int V_FRONT        = 10;
    localparam int V_SYNC         = 2;
    localparam int V_BACK         = 33;
    localparam int H_TOTAL        = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL        = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int WORDS_PER_LINE = H_VISIBLE / 4;
    localparam int FB_WORDS       = WORDS_PER_LINE * V_VISIBLE;
    localparam int HS_START       = H_VISIBLE + H_FRONT;
    localparam int HS_END         = HS_START + H_SYNC;
    localparam int VS_START       = V_VISIBLE + V_FRONT;
    localparam int VS_END         = VS_START + V_SYNC;
    localparam int READ_LATENCY   = 2;
    localparam bit SYNC_ACTIVE    = 1'b0;
    localparam int CW             = 10;
    localparam int AW             = 17;

    typedef logic [11:0] rgb_t;
    typedef logic [255:0][11:0] pal_mem_t;

    // Per-pixel side information that travels alongside the BRAM read.
    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       act;
        logic [1:0] sub;
    } pix_tag_t;

    function automatic rgb_t rgb332(input logic [7:0] i);
        return {i[7:5], i[7], i[4:2], i[4], i[1:0], i[1:0]};
    endfunction

    function automatic pal_mem_t pal_init();
        pal_mem_t p;
        for (int i = 0; i < 256; i++) p[i] = rgb332(8'(i));
        return p;
    endfunction
endpackage

// File: rtl/vga_palette.sv
// vga_palette: 256x12 colour table, synchronous write, registered read-first lookup.
// The registered read doubles as the colour output register; blank forces black.
module vga_palette
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       we_i,
    input  logic [7:0] waddr_i,
    input  rgb_t       wdata_i,
    input  logic [7:0] raddr_i,
    input  logic       blank_i,
    output rgb_t       rgb_o
);
    // Contents survive reset; only the power-up image is the RGB332 ramp.
    pal_mem_t mem_q = pal_init();
    rgb_t     rgb_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk) begin
        if (!resetn) rgb_q <= '0;
        else rgb_q <= blank_i ? '0 : mem_q[raddr_i];
    end

    assign rgb_o = rgb_q;
endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: framebuffer scanout with palette lookup and sync generation.
// Counters are stage 0; colour and syncs reach the pins READ_LAT+2 cycles later.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int H_VIS    = H_VISIBLE,
    parameter int H_FP     = H_FRONT,
    parameter int H_SW     = H_SYNC,
    parameter int H_BP     = H_BACK,
    parameter int V_VIS    = V_VISIBLE,
    parameter int V_FP     = V_FRONT,
    parameter int V_SW     = V_SYNC,
    parameter int V_BP     = V_BACK,
    parameter int READ_LAT = READ_LATENCY,
    parameter bit SYNC_POL = SYNC_ACTIVE
) (
    input  logic          clk,
    input  logic          resetn,
    output logic [AW-1:0] fb_addr,
    output logic          fb_en,
    input  logic [31:0]   fb_data,
    input  logic          pal_we,
    input  logic [7:0]    pal_addr,
    input  logic [11:0]   pal_data,
    output logic [3:0]    vga_red,
    output logic [3:0]    vga_green,
    output logic [3:0]    vga_blue,
    output logic          vga_hsync,
    output logic          vga_vsync,
    output logic          frame_start,
    output logic          vblank
);
    localparam logic [CW-1:0] H_LAST     = CW'(H_VIS + H_FP + H_SW + H_BP - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_VIS + V_FP + V_SW + V_BP - 1);
    localparam logic [CW-1:0] H_ACT      = CW'(H_VIS);
    localparam logic [CW-1:0] V_ACT      = CW'(V_VIS);
    localparam logic [CW-1:0] HS_LO      = CW'(H_VIS + H_FP);
    localparam logic [CW-1:0] HS_HI      = CW'(H_VIS + H_FP + H_SW);
    localparam logic [CW-1:0] VS_LO      = CW'(V_VIS + V_FP);
    localparam logic [CW-1:0] VS_HI      = CW'(V_VIS + V_FP + V_SW);
    localparam logic [AW-1:0] LINE_WORDS = AW'(H_VIS / 4);
    localparam pix_tag_t      IDLE       = '{hs: !SYNC_POL, vs: !SYNC_POL, act: 1'b0, sub: 2'b00};

    logic [CW-1:0]         hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [AW-1:0]         base_q, base_d, fb_addr_q;
    logic                  fb_en_q, hs_q, vs_q, h_end, v_end;
    pix_tag_t              tag;
    pix_tag_t [READ_LAT:0] dly_q;
    rgb_t                  rgb;

    // Line base steps by one line of words, so no multiply is needed for the address.
    always_comb begin
        h_end   = hcnt_q == H_LAST;
        v_end   = vcnt_q == V_LAST;
        hcnt_d  = h_end ? '0 : hcnt_q + 1'b1;
        vcnt_d  = !h_end ? vcnt_q : (v_end ? '0 : vcnt_q + 1'b1);
        base_d  = !h_end ? base_q : (v_end ? '0 : (vcnt_q < V_ACT ? base_q + LINE_WORDS : base_q));
        tag.act = hcnt_q < H_ACT && vcnt_q < V_ACT;
        tag.hs  = (hcnt_q >= HS_LO && hcnt_q < HS_HI) ? SYNC_POL : !SYNC_POL;
        tag.vs  = (vcnt_q >= VS_LO && vcnt_q < VS_HI) ? SYNC_POL : !SYNC_POL;
        tag.sub = hcnt_q[1:0];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            base_q    <= '0;
            fb_addr_q <= '0;
            fb_en_q   <= 1'b0;
            dly_q     <= {(READ_LAT + 1){IDLE}};
            hs_q      <= !SYNC_POL;
            vs_q      <= !SYNC_POL;
        end else begin
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            base_q    <= base_d;
            fb_addr_q <= base_q + AW'(hcnt_q[CW-1:2]);
            fb_en_q   <= tag.act;
            dly_q     <= {dly_q[READ_LAT-1:0], tag};
            hs_q      <= dly_q[READ_LAT].hs;
            vs_q      <= dly_q[READ_LAT].vs;
        end
    end

    vga_palette u_pal (
        .clk     (clk),
        .resetn  (resetn),
        .we_i    (pal_we),
        .waddr_i (pal_addr),
        .wdata_i (pal_data),
        .raddr_i (fb_data[{dly_q[READ_LAT].sub, 3'b000} +: 8]),
        .blank_i (!dly_q[READ_LAT].act),
        .rgb_o   (rgb)
    );

    assign fb_addr     = fb_addr_q;
    assign fb_en       = fb_en_q;
    assign vga_red     = rgb[11:8];
    assign vga_green   = rgb[7:4];
    assign vga_blue    = rgb[3:0];
    assign vga_hsync   = hs_q;
    assign vga_vsync   = vs_q;
    assign frame_start = resetn && hcnt_q == '0 && vcnt_q == '0;
    assign vblank      = vcnt_q >= V_ACT;
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: full-size instance for line-level vectors, shrunken-timing instance
// for frame period, vsync, palette write and mid-frame reset sequences.
module tb_vga_scanout;
    typedef struct {
        int          cyc;
        logic [11:0] rgb;
        logic        hs;
        logic [16:0] addr;
        logic        en;
        logic        fs;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn_a = 1'b0, rstn_b = 1'b0;
    logic [16:0] a_addr, b_addr;
    logic        a_en, b_en;
    logic [31:0] a_data = '0, a_pipe = '0, b_data = '0;
    logic        a_we = 1'b0, b_we = 1'b0;
    logic [7:0]  a_pa = '0, b_pa = '0;
    logic [11:0] a_pd = '0, b_pd = '0;
    logic [3:0]  a_r, a_g, a_b, b_r, b_g, b_b;
    logic        a_hs, a_vs, a_fs, a_vb, b_hs, b_vs, b_fs, b_vb;
    int          n_tests = 0, n_fail = 0;
    int          idx = 0;
    vec_t        tbl[21];

    always #5 clk = ~clk;

    vga_scanout dut_a (
        .clk(clk), .resetn(rstn_a), .fb_addr(a_addr), .fb_en(a_en), .fb_data(a_data),
        .pal_we(a_we), .pal_addr(a_pa), .pal_data(a_pd),
        .vga_red(a_r), .vga_green(a_g), .vga_blue(a_b),
        .vga_hsync(a_hs), .vga_vsync(a_vs), .frame_start(a_fs), .vblank(a_vb)
    );

    vga_scanout #(.H_VIS(8), .H_FP(2), .H_SW(3), .H_BP(3), .V_VIS(4), .V_FP(1), .V_SW(2), .V_BP(1)) dut_b (
        .clk(clk), .resetn(rstn_b), .fb_addr(b_addr), .fb_en(b_en), .fb_data(b_data),
        .pal_we(b_we), .pal_addr(b_pa), .pal_data(b_pd),
        .vga_red(b_r), .vga_green(b_g), .vga_blue(b_b),
        .vga_hsync(b_hs), .vga_vsync(b_vs), .frame_start(b_fs), .vblank(b_vb)
    );

    function automatic logic [31:0] word_at(input logic [16:0] a);
        return a == 17'd0 ? 32'h03E0_1CFF : (a == 17'd1 ? 32'h1234_5678 : 32'h0);
    endfunction

    // Two-cycle BRAM: registered address in, data two edges later.
    always @(posedge clk) begin
        if (a_en) a_pipe <= word_at(a_addr);
        a_data <= a_pipe;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int w, k, vb_n, vs_n, hs_n, fs_n, hs_fall, vs_fall;
        logic prev_hs, prev_vs;
        tbl = '{
            '{0,   12'h000, 1'b1, 17'd0,   1'b0, 1'b1},
            '{1,   12'h000, 1'b1, 17'd0,   1'b1, 1'b0},
            '{3,   12'h000, 1'b1, 17'd0,   1'b1, 1'b0},
            '{4,   12'hFFF, 1'b1, 17'd0,   1'b1, 1'b0},
            '{5,   12'h0F0, 1'b1, 17'd1,   1'b1, 1'b0},
            '{6,   12'hF00, 1'b1, 17'd1,   1'b1, 1'b0},
            '{7,   12'h00F, 1'b1, 17'd1,   1'b1, 1'b0},
            '{8,   12'h6D0, 1'b1, 17'd1,   1'b1, 1'b0},
            '{9,   12'h4BA, 1'b1, 17'd2,   1'b1, 1'b0},
            '{10,  12'h2B0, 1'b1, 17'd2,   1'b1, 1'b0},
            '{11,  12'h09A, 1'b1, 17'd2,   1'b1, 1'b0},
            '{12,  12'h000, 1'b1, 17'd2,   1'b1, 1'b0},
            '{640, 12'h000, 1'b1, 17'd159, 1'b1, 1'b0},
            '{641, 12'h000, 1'b1, 17'd160, 1'b0, 1'b0},
            '{659, 12'h000, 1'b1, 17'd164, 1'b0, 1'b0},
            '{660, 12'h000, 1'b0, 17'd164, 1'b0, 1'b0},
            '{755, 12'h000, 1'b0, 17'd188, 1'b0, 1'b0},
            '{756, 12'h000, 1'b1, 17'd188, 1'b0, 1'b0},
            '{800, 12'h000, 1'b1, 17'd199, 1'b0, 1'b0},
            '{801, 12'h000, 1'b1, 17'd160, 1'b1, 1'b0},
            '{805, 12'h000, 1'b1, 17'd161, 1'b1, 1'b0}
        };
        repeat (5) step();
        chk("rst_rgb", {a_r, a_g, a_b}, 12'h000);
        chk("rst_hs", a_hs, 1'b1);
        chk("rst_vs", a_vs, 1'b1);
        chk("rst_en", a_en, 1'b0);
        chk("rst_addr", a_addr, 17'd0);
        chk("rst_fs", a_fs, 1'b0);
        chk("rst_vb", a_vb, 1'b0);
        @(negedge clk);
        rstn_a = 1'b1;
        rstn_b = 1'b1;
        #1;
        for (int c = 0; c <= 805; c++) begin
            if (c > 0) step();
            while (idx < 21 && tbl[idx].cyc == c) begin
                chk($sformatf("c%0d_rgb", c), {a_r, a_g, a_b}, tbl[idx].rgb);
                chk($sformatf("c%0d_hs", c), a_hs, tbl[idx].hs);
                chk($sformatf("c%0d_vs", c), a_vs, 1'b1);
                chk($sformatf("c%0d_addr", c), a_addr, tbl[idx].addr);
                chk($sformatf("c%0d_en", c), a_en, tbl[idx].en);
                chk($sformatf("c%0d_fs", c), a_fs, tbl[idx].fs);
                idx++;
            end
        end
        w = 0;
        while (!b_fs && w < 300) begin
            step();
            w++;
        end
        chk("b_sync", b_fs, 1'b1);
        vb_n = 0; vs_n = 0; hs_n = 0; fs_n = 0; hs_fall = -1; vs_fall = -1;
        prev_hs = b_hs; prev_vs = b_vs;
        for (k = 0; k < 128; k++) begin
            vb_n += int'(b_vb);
            vs_n += int'(!b_vs);
            hs_n += int'(!b_hs);
            fs_n += int'(b_fs);
            if (k > 0 && prev_hs && !b_hs && hs_fall < 0) hs_fall = k;
            if (k > 0 && prev_vs && !b_vs && vs_fall < 0) vs_fall = k;
            prev_hs = b_hs;
            prev_vs = b_vs;
            if (k == 1) begin
                chk("b_addr_first", b_addr, 17'd0);
                chk("b_en_first", b_en, 1'b1);
            end
            if (k == 56) begin
                chk("b_addr_last", b_addr, 17'd7);
                chk("b_en_last", b_en, 1'b1);
            end
            if (k == 57) begin
                chk("b_addr_past", b_addr, 17'd8);
                chk("b_en_past", b_en, 1'b0);
            end
            step();
        end
        chk("b_vblank_cycles", vb_n, 64);
        chk("b_vsync_cycles", vs_n, 32);
        chk("b_hsync_cycles", hs_n, 24);
        chk("b_fs_pulses", fs_n, 1);
        chk("b_hsync_fall", hs_fall, 14);
        chk("b_vsync_fall", vs_fall, 84);
        chk("b_frame_period", b_fs, 1'b1);
        repeat (70) step();
        b_we = 1'b1; b_pa = 8'h00; b_pd = 12'h111;
        step();
        b_we = 1'b0;
        repeat (57) step();
        chk("b_frame3", b_fs, 1'b1);
        repeat (3) step();
        b_we = 1'b1; b_pa = 8'h00; b_pd = 12'hABC;
        step();
        b_we = 1'b0;
        chk("pal_read_first", {b_r, b_g, b_b}, 12'h111);
        step();
        chk("pal_new_px1", {b_r, b_g, b_b}, 12'hABC);
        repeat (6) step();
        chk("pal_new_px7", {b_r, b_g, b_b}, 12'hABC);
        step();
        chk("pal_blank_px8", {b_r, b_g, b_b}, 12'h000);
        repeat (8) step();
        chk("pal_line1", {b_r, b_g, b_b}, 12'hABC);
        repeat (17) step();
        chk("mid_pre_rgb", {b_r, b_g, b_b}, 12'hABC);
        rstn_b = 1'b0;
        step();
        chk("mid_rgb", {b_r, b_g, b_b}, 12'h000);
        chk("mid_en", b_en, 1'b0);
        chk("mid_hs", b_hs, 1'b1);
        chk("mid_vb", b_vb, 1'b0);
        rstn_b = 1'b1;
        #1;
        chk("mid_fs", b_fs, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            step();
            chk($sformatf("mid_c%0d_rgb", c), {b_r, b_g, b_b}, c < 4 ? 12'h000 : 12'hABC);
            if (c == 1) begin
                chk("mid_addr", b_addr, 17'd0);
                chk("mid_en_restart", b_en, 1'b1);
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
